// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment display.
// Segment vectors are ordered {g,f,e,d,c,b,a}, and all outputs are active-low.
package seg7_pkg;

  localparam int DIGIT_COUNT = 4;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Entry [n] is the glyph for decimal digit n.
  localparam logic [9:0][6:0] SEG_PATTERNS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic       DP_OFF   = 1'b1;

endpackage

// File: rtl/seg7_time_display_if.sv
// Display bus: the BCD readings and run flag going in, and the anode, segment
// and decimal-point drives coming out.
interface seg7_time_display_if;

  logic [7:0] time_reading;
  logic [7:0] aux_reading;
  logic       count_enabled;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output time_reading, aux_reading, count_enabled,
    input  an, seg, dp
  );

  modport slave (
    input  time_reading, aux_reading, count_enabled,
    output an, seg, dp
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD-to-seven-segment decoder (active-low, {g,f,e,d,c,b,a}).
// Nibble values 10 through 15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: assign a default first so every path drives o_seg and no latch is inferred.
    o_seg = SEG_DASH;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_PATTERNS[i_bcd];
    end
  end

endmodule

// File: rtl/seg7_time_display.sv
// Four-digit multiplexed time display with per-frame input snapshots, anti-ghost
// blanking and a separator dot that blinks while paused.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank zero tens digits (1 and 3).
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int DIGIT_PERIOD = 25000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                init_regs_n,
  seg7_time_display_if.slave  bus
);

  localparam int SLOT_W     = $clog2(DIGIT_PERIOD);
  localparam int BLINK_HALF = (CLK_FREQ / 2 > 1) ? CLK_FREQ / 2 : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_PERIOD - 1);
  localparam logic [SLOT_W-1:0]  SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [SLOT_W-1:0]  r_slot_cnt;
  digit_e             r_digit_idx;
  logic [7:0]         r_time_snap;
  logic [7:0]         r_aux_snap;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_lit;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic [3:0] w_nibble;
  logic [6:0] w_seg;
  logic       w_active;
  logic       w_lz_blank;
  logic [3:0] w_an_next;
  logic       w_dp_next;

  // Scan timing. The snapshot is refreshed only on the 3->0 digit wrap, so each
  // frame shows one coherent reading.
  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= DIG0;
      r_time_snap <= '0;
      r_aux_snap  <= '0;
    end else begin
      // NOTE: use non-blocking assignments so every register updates from pre-edge values.
      if (r_slot_cnt == SLOT_LAST) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= digit_e'(r_digit_idx + 2'd1);
        if (r_digit_idx == DIG3) begin
          r_time_snap <= bus.time_reading;
          r_aux_snap  <= bus.aux_reading;
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
    end
  end

  // While running, the counter is held so that every pause starts with a full lit half-period.
  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      r_blink_cnt <= '0;
      r_blink_lit <= 1'b1;
    end else if (bus.count_enabled) begin
      r_blink_cnt <= '0;
      r_blink_lit <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_lit <= ~r_blink_lit;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nibble = r_time_snap[3:0];
    case (r_digit_idx)
      DIG0: w_nibble = r_time_snap[3:0];
      DIG1: w_nibble = r_time_snap[7:4];
      DIG2: w_nibble = r_aux_snap[3:0];
      DIG3: w_nibble = r_aux_snap[7:4];
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .i_bcd (w_nibble),
    .o_seg (w_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign w_lz_blank = ((r_digit_idx == DIG1) || (r_digit_idx == DIG3)) && (w_nibble == 4'd0);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_active  = (r_slot_cnt >= SLOT_BLANK);
  assign w_an_next = (w_active && !w_lz_blank) ? ~(4'b0001 << r_digit_idx) : AN_OFF;
  assign w_dp_next = ~(w_active && (r_digit_idx == DIG2) && r_blink_lit);

  // Registered drives; the async reset turns the display off without waiting for a clock.
  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg;
      r_dp  <= w_dp_next;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
